soup_loader: RTL and testbench
==============================

// Module: soup_loader
// PURPOSE
//   Consumer end of the random-soup generator. On start, snapshots the NI-bit soup word
//   (INIT x INIT cells, row-major) and streams it row by row into the life-board
//   loader over a valid/ready handshake. It accumulates the live-cell population of
//   the soup for host-side statistics and flags completion with a one-cycle done pulse.
// PARAMETERS
//   INIT  20                   board side in cells; one row = INIT bits
//   NI    INIT*INIT (local)    soup word width
//   ROWW  $clog2(INIT) (local) row index width (5 for INIT=20)
//   POPW  $clog2(NI+1) (local) population counter width (9 for INIT=20)
// PORTS
//   clk        in   1     system clock, all state on posedge
//   reset_n    in   1     asynchronous, active-low reset
//   start      in   1     request a new soup load; sampled only in IDLE
//   x          in   NI    soup word from rng; bit r*INIT+c = cell (row r, col c)
//   busy       out  1     high whenever state != IDLE
//   row_valid  out  1     row_data/row_idx/row_last are valid
//   row_ready  in   1     downstream accepts the row when high with row_valid
//   row_data   out  INIT  cells of current row; bit c = column c
//   row_idx    out  ROWW  index of current row, 0..INIT-1
//   row_last   out  1     high with row_valid when row_idx == INIT-1
//   pop_total  out  POPW  live-cell count of the rows transferred so far
//   done       out  1     one-cycle pulse after the last row transfer
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, snapshot=0, row_idx=0, pop_total=0,
//     every other output 0. Asserting reset mid-stream aborts the load. No done pulse.
//   States: IDLE -> STREAM -> DONE -> IDLE.
//   IDLE: busy=0, row_valid=0. If start=1 at an edge, snapshot<=x, row_idx<=0,
//     pop_total<=0, then go to STREAM. The first row_valid is in the next cycle
//     (1-cycle latency).
//   STREAM: row_valid=1, row_data=snapshot[row_idx*INIT +: INIT], row_last=(row_idx==INIT-1).
//     A transfer happens at an edge with row_valid & row_ready: pop_total += popcount(row_data).
//     If row_last, go to DONE and hold row_idx. Otherwise row_idx += 1.
//     With row_ready=0, all row outputs hold stable indefinitely. There is no timeout.
//   DONE: row_valid=0, done=1 for exactly this one cycle, busy=1. Go to IDLE at next edge.
//   start is ignored in STREAM and DONE. It is not queued. The snapshot is not disturbed
//     by later changes on x.
//   pop_total holds its final value, 0..NI, from DONE until the next accepted start.
//     POPW is sized so the value never wraps.
//   popcount is combinational over INIT bits and is added in the same cycle as the transfer.
//   row_idx never exceeds INIT-1. There is no wrap inside one load.
// TESTING
//   x=0, start pulse, row_ready=1 -> 20 rows of 0, row_idx 0..19, row_last on row 19,
//     done pulse 21 cycles after start, pop_total=0.
//   x=all-ones, row_ready=1 -> every row_data=20'hFFFFF, pop_total=400 at done.
//   x with only bit r*20+r set for each row r (diagonal) -> row r has only bit r set,
//     pop_total=20.
//   Random x, row_ready toggled pseudo-randomly -> row_data stable while stalled,
//     rows match x in order, pop_total=popcount(x).
//   Change x and pulse start during STREAM -> ignored. Rows still match the first
//     snapshot, and exactly one done pulse occurs.
//   Assert reset_n=0 after row 7 transfers -> outputs 0 asynchronously, no done pulse.
//     A new start then streams from row 0 with pop_total restarting at 0.

Source files
------------

// File: rtl/soup_loader.sv
// Soup loader: snapshots an INIT x INIT random soup word on start and streams it
// row by row over a valid/ready handshake, accumulating the live-cell population.
module soup_loader #(
  parameter  int INIT = 20,
  localparam int NI   = INIT * INIT,
  localparam int ROWW = $clog2(INIT),
  localparam int POPW = $clog2(NI + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [NI-1:0]   x,
  output logic            busy,
  output logic            row_valid,
  input  logic            row_ready,
  output logic [INIT-1:0] row_data,
  output logic [ROWW-1:0] row_idx,
  output logic            row_last,
  output logic [POPW-1:0] pop_total,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [NI-1:0]   snapshot;
  logic [INIT-1:0] cur_row;
  logic [POPW-1:0] row_pop;
  logic            at_last;

  function automatic logic [POPW-1:0] popcount(input logic [INIT-1:0] v);
    logic [POPW-1:0] n;
    n = '0;
    for (int i = 0; i < INIT; i++) begin
      n = n + POPW'(v[i]);
    end
    return n;
  endfunction

  assign cur_row = snapshot[row_idx*INIT +: INIT];
  assign row_pop = popcount(cur_row);
  assign at_last = (row_idx == ROWW'(INIT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Row outputs are forced to zero outside STREAM so idle/done never show stale rows.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    row_valid  = 1'b0;
    row_data   = '0;
    row_last   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = STREAM;
      end
      STREAM: begin
        row_valid = 1'b1;
        row_data  = cur_row;
        row_last  = at_last;
        if (row_ready && at_last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // row_idx holds on the last row so it never leaves 0..INIT-1 within a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot  <= '0;
      row_idx   <= '0;
      pop_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot  <= x;
            row_idx   <= '0;
            pop_total <= '0;
          end
        end
        STREAM: begin
          if (row_ready) begin
            pop_total <= pop_total + row_pop;
            if (!at_last) row_idx <= row_idx + ROWW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soup_loader.sv
// Self-checking bench for soup_loader: table of soup loads checked cycle by cycle
// against a row-list reference model, plus a hand-written mid-stream reset sequence.
module tb_soup_loader;

  localparam int INIT = 20;
  localparam int NI   = INIT * INIT;
  localparam int ROWW = $clog2(INIT);
  localparam int POPW = $clog2(NI + 1);

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [NI-1:0]   x;
  logic            busy;
  logic            row_valid;
  logic            row_ready;
  logic [INIT-1:0] row_data;
  logic [ROWW-1:0] row_idx;
  logic            row_last;
  logic [POPW-1:0] pop_total;
  logic            done;

  int checkCount;
  int errorCount;

  typedef struct {
    logic [NI-1:0] soup;
    int            readyPct;
    int            disturbAt;
    int            expPop;
  } vec_t;

  vec_t table_q[6];

  soup_loader #(.INIT(INIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x         (x),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .pop_total (pop_total),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference view of the soup: a list of rows, row r column c = bit r*INIT+c.
  function automatic logic [INIT-1:0] modelRow(input logic [NI-1:0] soup, input int r);
    logic [INIT-1:0] v;
    for (int c = 0; c < INIT; c++) v[c] = soup[r*INIT + c];
    return v;
  endfunction

  function automatic logic [NI-1:0] randomSoup();
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = 1'($urandom_range(1));
    return v;
  endfunction

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(row_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(row_data), 32'd0);
    checkOutput({tag, "_last"}, 32'(row_last), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Runs one load from a start pulse; returns early once abortAt rows have transferred.
  task automatic applyStimulus(input logic [NI-1:0] soup, input int readyPct,
                               input int disturbAt, input int expPop, input int abortAt);
    logic [INIT-1:0] rows[INIT];
    logic [INIT-1:0] prevData;
    int              expRow;
    int              runPop;
    int              cycles;
    bit              gotDone;
    bit              stalled;
    bit              rdy;
    for (int r = 0; r < INIT; r++) rows[r] = modelRow(soup, r);
    @(negedge clk);
    x     = soup;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    x       = ~soup;
    expRow  = 0;
    runPop  = 0;
    cycles  = 0;
    gotDone = 1'b0;
    stalled = 1'b0;
    prevData = '0;
    while (!gotDone && cycles < 2000) begin
      if (abortAt >= 0 && expRow >= abortAt) return;
      if (expRow == INIT) begin
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_valid", 32'(row_valid), 32'd0);
        checkOutput("pop_final", 32'(pop_total), 32'(expPop));
        checkOutput("pop_model", 32'(pop_total), 32'(runPop));
        gotDone = 1'b1;
      end else begin
        checkOutput("row_valid", 32'(row_valid), 32'd1);
        checkOutput("busy", 32'(busy), 32'd1);
        checkOutput("done_early", 32'(done), 32'd0);
        checkOutput("row_idx", 32'(row_idx), 32'(expRow));
        checkOutput("row_data", 32'(row_data), 32'(rows[expRow]));
        checkOutput("row_last", 32'(row_last), 32'(expRow == INIT - 1));
        checkOutput("pop_run", 32'(pop_total), 32'(runPop));
        if (stalled) checkOutput("stall_stable", 32'(row_data), 32'(prevData));
        prevData = row_data;
        rdy = ($urandom_range(99) < readyPct);
        row_ready = rdy;
        if (expRow == disturbAt) begin
          start = 1'b1;
          x     = randomSoup();
        end
        @(negedge clk);
        start = 1'b0;
        stalled = !rdy;
        if (rdy) begin
          runPop += $countones(rows[expRow]);
          expRow++;
        end
      end
      cycles++;
    end
    if (!gotDone) checkOutput("done_timeout", 32'(gotDone), 32'd1);
    row_ready = 1'b0;
    // No second done and a clean return to idle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkIdleZero("after_done");
      checkOutput("pop_hold", 32'(pop_total), 32'(expPop));
    end
  endtask

  initial begin
    logic [NI-1:0] diag;
    checkCount = 0;
    errorCount = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    row_ready  = 1'b0;
    x          = '0;
    #1;
    checkIdleZero("reset");
    checkOutput("reset_idx", 32'(row_idx), 32'd0);
    checkOutput("reset_pop", 32'(pop_total), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    diag = '0;
    for (int r = 0; r < INIT; r++) diag[r*INIT + r] = 1'b1;
    table_q[0] = '{soup: '0, readyPct: 100, disturbAt: -1, expPop: 0};
    table_q[1] = '{soup: '1, readyPct: 100, disturbAt: -1, expPop: 400};
    table_q[2] = '{soup: diag, readyPct: 100, disturbAt: -1, expPop: 20};
    for (int i = 3; i < 6; i++) begin
      table_q[i].soup      = randomSoup();
      table_q[i].readyPct  = (i == 5) ? 70 : 50;
      table_q[i].disturbAt = (i == 5) ? 6 : -1;
      table_q[i].expPop    = $countones(table_q[i].soup);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(table_q[i].soup, table_q[i].readyPct, table_q[i].disturbAt,
                    table_q[i].expPop, -1);
    end

    // Abort after rows 0..7 transfer: async clear, no done, then a fresh load.
    diag = randomSoup();
    applyStimulus(diag, 100, -1, $countones(diag), 8);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdleZero("abort");
    checkOutput("abort_idx", 32'(row_idx), 32'd0);
    checkOutput("abort_pop", 32'(pop_total), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    diag = randomSoup();
    applyStimulus(diag, 60, -1, $countones(diag), -1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
